multi_channel_scaler: RTL and testbench

- Parametrised successor to the single-channel gain/shift scaler in the MIDI-player audio path.
- Scales a stream of unsigned samples tagged with a channel index: out = sat((sample * gain[ch]) >> shift[ch]).
- Holds per-channel gain and shift in a register file written through a config port.
- Two-stage pipeline with valid/ready handshake, saturation, and sticky per-channel overflow flags; sits between voice generators and the mixer.

---
 rtl/scaler_pkg.sv | 23 ++
 rtl/scaler_cfg_regs.sv | 50 +++++
 rtl/multi_channel_scaler.sv | 130 +++++++++++++
 tb/tb_multi_channel_scaler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared widths, reset constants and the stage-1 payload for the multi-channel scaler.
package scaler_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_GAIN_W  = 16;
  localparam int unsigned DEF_SHIFT_W = 5;
  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_CH_W    = $clog2(DEF_NUM_CH);
  localparam int unsigned DEF_PROD_W  = DEF_DATA_W + DEF_GAIN_W;

  // Passthrough configuration restored on reset.
  localparam logic [DEF_GAIN_W-1:0]  GAIN_UNITY = DEF_GAIN_W'(1);
  localparam logic [DEF_SHIFT_W-1:0] SHIFT_ZERO = DEF_SHIFT_W'(0);

  // Stage-1 register: full-precision product plus the shift it must be scaled by.
  typedef struct packed {
    logic                   valid;
    logic [DEF_CH_W-1:0]    ch;
    logic [DEF_PROD_W-1:0]  prod;
    logic [DEF_SHIFT_W-1:0] shift;
  } s1_payload_t;

endpackage

// File: rtl/scaler_cfg_regs.sv
// Per-channel gain/shift register file: one write port, combinational read by channel.
// Unknown channels read back as gain 0 / shift 0 so their samples come out as 0.
module scaler_cfg_regs
  import scaler_pkg::*;
#(
  parameter int unsigned GAIN_W  = DEF_GAIN_W,
  parameter int unsigned SHIFT_W = DEF_SHIFT_W,
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [GAIN_W-1:0]  wr_gain,
  input  logic [SHIFT_W-1:0] wr_shift,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [GAIN_W-1:0]  rd_gain_c,
  output logic [SHIFT_W-1:0] rd_shift_c
);

  logic [GAIN_W-1:0]  gain  [NUM_CH];
  logic [SHIFT_W-1:0] shift [NUM_CH];
  logic               rd_ok;

  // Register file update; reset returns every channel to passthrough.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        gain[i]  <= GAIN_W'(GAIN_UNITY);
        shift[i] <= SHIFT_W'(SHIFT_ZERO);
      end
    end else if (we && (32'(wr_ch) < NUM_CH)) begin
      gain[wr_ch]  <= wr_gain;
      shift[wr_ch] <= wr_shift;
    end
  end

  // Combinational read for the sample being accepted this cycle.
  always_comb begin
    rd_ok      = (32'(rd_ch) < NUM_CH);
    rd_gain_c  = '0;
    rd_shift_c = '0;
    if (rd_ok) begin
      rd_gain_c  = gain[rd_ch];
      rd_shift_c = shift[rd_ch];
    end
  end

endmodule

// File: rtl/multi_channel_scaler.sv
// Two-stage per-channel gain/shift scaler with saturation and sticky overflow flags.
// Optional: define SCALER_ROUND_EN for round-half-up instead of truncation.
module multi_channel_scaler
  import scaler_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned GAIN_W  = DEF_GAIN_W,
  parameter int unsigned SHIFT_W = DEF_SHIFT_W,
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sat,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [GAIN_W-1:0]  cfg_gain,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic [NUM_CH-1:0]  ovf_flags,
  input  logic               ovf_clr
);

  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned EXT_W  = PROD_W + 1;

  logic               adv;
  logic [GAIN_W-1:0]  rd_gain;
  logic [SHIFT_W-1:0] rd_shift;
  s1_payload_t        s1;
  logic [EXT_W-1:0]   sum;
  logic [EXT_W-1:0]   r;
  logic               s2_sat;
  logic [DATA_W-1:0]  s2_data;
  logic [NUM_CH-1:0]  ovf_set;

  scaler_cfg_regs #(
    .GAIN_W  (GAIN_W),
    .SHIFT_W (SHIFT_W),
    .NUM_CH  (NUM_CH),
    .CH_W    (CH_W)
  ) u_cfg (
    .clk        (clk),
    .reset      (reset),
    .we         (cfg_we),
    .wr_ch      (cfg_ch),
    .wr_gain    (cfg_gain),
    .wr_shift   (cfg_shift),
    .rd_ch      (in_ch),
    .rd_gain_c  (rd_gain),
    .rd_shift_c (rd_shift)
  );

  // Pipeline moves whenever the output slot is empty or being drained.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // Stage 1: full-precision multiply using the config seen before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else if (adv) begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.ch    <= in_ch;
        s1.prod  <= PROD_W'(in_data) * PROD_W'(rd_gain);
        s1.shift <= rd_shift;
      end
    end
  end

  // Stage 2 math: optional rounding (one extra bit so it cannot wrap), shift, saturate.
  always_comb begin
`ifdef SCALER_ROUND_EN
    sum = {1'b0, s1.prod};
    if (s1.shift != '0) begin
      sum = {1'b0, s1.prod} + (EXT_W'(1) << (s1.shift - SHIFT_W'(1)));
    end
`else
    sum = {1'b0, s1.prod};
`endif
    r       = sum >> s1.shift;
    s2_sat  = |r[EXT_W-1:DATA_W];
    s2_data = s2_sat ? '1 : r[DATA_W-1:0];
  end

  // Stage 2 output register; holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1.valid;
      if (s1.valid) begin
        out_ch   <= s1.ch;
        out_data <= s2_data;
        out_sat  <= s2_sat;
      end
    end
  end

  // A saturated sample leaving the block marks its channel.
  always_comb begin
    ovf_set = '0;
    if (out_valid && out_ready && out_sat) begin
      ovf_set = NUM_CH'(1) << out_ch;
    end
  end

  // Sticky flags; a new set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_flags <= '0;
    end else begin
      ovf_flags <= (ovf_clr ? '0 : ovf_flags) | ovf_set;
    end
  end

endmodule

// File: tb/tb_multi_channel_scaler.sv
// Directed self-checking bench for multi_channel_scaler (default widths, 4 channels).
module tb_multi_channel_scaler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        out_sat;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_gain;
  logic [4:0]  cfg_shift;
  logic [3:0]  ovf_flags;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;

`ifdef SCALER_ROUND_EN
  localparam logic [15:0] EXP_CH1 = 16'h0D00;
`else
  localparam logic [15:0] EXP_CH1 = 16'h0CFF;
`endif

  multi_channel_scaler dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_gain  (cfg_gain),
    .cfg_shift (cfg_shift),
    .ovf_flags (ovf_flags),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] ch, input logic [15:0] d,
                           input logic sat);
    check({tag, " valid"}, 32'(out_valid), 32'(1));
    check({tag, " ch"},    32'(out_ch),    32'(ch));
    check({tag, " data"},  32'(out_data),  32'(d));
    check({tag, " sat"},   32'(out_sat),   32'(sat));
  endtask

  // Called at a falling edge; write lands on the next rising edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] g, input logic [4:0] s);
    cfg_we = 1'b1; cfg_ch = ch; cfg_gain = g; cfg_shift = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One isolated sample; result must appear exactly two edges after acceptance.
  task automatic run1(input string tag, input logic [1:0] ch, input logic [15:0] d,
                      input logic [15:0] exp, input logic sat);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    check({tag, " ready"}, 32'(in_ready), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " lat1"}, 32'(out_valid), 32'(0));
    @(negedge clk);
    check_out(tag, ch, exp, sat);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_gain = '0; cfg_shift = '0; ovf_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'(0));
    check("rst out_data",  32'(out_data),  32'(0));
    check("rst out_ch",    32'(out_ch),    32'(0));
    check("rst out_sat",   32'(out_sat),   32'(0));
    check("rst ovf",       32'(ovf_flags), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready",  32'(in_ready),  32'(1));

    // Passthrough default
    run1("pass ch2", 2'd2, 16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    check("pass drained", 32'(out_valid), 32'(0));

    // Gain and shift
    cfg_write(2'd0, 16'd8, 5'd0);
    run1("ch0 x8", 2'd0, 16'h0001, 16'h0008, 1'b0);
    cfg_write(2'd1, 16'd13, 5'd8);
    run1("ch1 x13>>8", 2'd1, 16'hFFFF, EXP_CH1, 1'b0);

    // Config write coincident with acceptance uses old values
    cfg_write(2'd3, 16'd16, 5'd0);
    run1("ch3 x16", 2'd3, 16'h0FFF, 16'hFFF0, 1'b0);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_gain = 16'd16; cfg_shift = 5'd4;
    in_valid = 1'b1; in_ch = 2'd3; in_data = 16'h0FFF;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_out("ch3 old cfg", 2'd3, 16'hFFF0, 1'b0);
    @(negedge clk);
    check_out("ch3 new cfg", 2'd3, 16'h0FFF, 1'b0);

    // Saturation and sticky flags
    cfg_write(2'd0, 16'd2, 5'd0);
    run1("ch0 sat", 2'd0, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    check("ovf set", 32'(ovf_flags), 32'h1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf clr", 32'(ovf_flags), 32'h0);
    run1("ch0 sat2", 2'd0, 16'hFFFF, 16'hFFFF, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf set wins", 32'(ovf_flags), 32'h1);

    // gain 0 gives 0, not saturated
    cfg_write(2'd2, 16'd0, 5'd0);
    run1("ch2 g0", 2'd2, 16'hFFFF, 16'h0000, 1'b0);
    cfg_write(2'd2, 16'd1, 5'd0);

    // Streaming with 3 cycles of backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h0100;
    @(negedge clk);
    in_ch = 2'd1; in_data = 16'hFFFF;
    @(negedge clk);
    in_ch = 2'd2; in_data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      check("bp in_ready", 32'(in_ready), 32'(0));
      check_out("bp hold s0", 2'd0, 16'h0200, 1'b0);
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_ch = 2'd3; in_data = 16'h0ABC;
    check_out("stream s1", 2'd1, EXP_CH1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("stream s2", 2'd2, 16'h1234, 1'b0);
    @(negedge clk);
    check_out("stream s3", 2'd3, 16'h0ABC, 1'b0);
    @(negedge clk);
    check("stream end", 32'(out_valid), 32'(0));

    // Reset with two samples in flight
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h0011;
    @(negedge clk);
    in_ch = 2'd1; in_data = 16'h0022;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("flush valid", 32'(out_valid), 32'(0));
    check("flush ovf",   32'(ovf_flags), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush quiet", 32'(out_valid), 32'(0));
    end
    run1("unity ch0", 2'd0, 16'h1234, 16'h1234, 1'b0);
    run1("unity ch1", 2'd1, 16'hFFFF, 16'hFFFF, 1'b0);
    run1("unity ch3", 2'd3, 16'h0FFF, 16'h0FFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
